cnn_job_sequencer: RTL and testbench

Job-level controller for the CNN streaming accelerator and its DMA wrapper. Receives per-job configuration descriptors (image dimension, 9 kernel weights, bias) on a byte-wide AXI-Stream config port and double-buffers them. Drives the accelerator's kernel_weights and image_dimension as stable registered outputs, holds the accelerator in reset between jobs, and gates the pixel stream. Counts input and output pixel handshakes to detect job completion, and flags malformed descriptors, tlast mismatches and stalls.

---
 rtl/cnn_job_sequencer_pkg.sv | 24 ++
 rtl/cnn_job_sequencer_if.sv | 12 +
 rtl/cnn_job_sequencer_cfg_desc_loader.sv | 78 +++++++
 rtl/cnn_job_sequencer.sv | 124 ++++++++++++
 tb/tb_cnn_job_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_job_sequencer_pkg.sv
// Shared constants, job-state encodings and sizing helpers for the CNN job sequencer.
package cnn_pkg;

  localparam int WEIGHT_RES_DEF   = 8;
  localparam int KERNEL_WIDTH_DEF = 3;
  localparam int KERNEL_SIZE_DEF  = 9;
  localparam int MAX_DIM_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF  = 1024;
  localparam int DESC_LEN         = KERNEL_SIZE_DEF + 2;

  typedef logic [2:0] job_state_t;

  localparam job_state_t ST_IDLE  = 3'd0;
  localparam job_state_t ST_ARM   = 3'd1;
  localparam job_state_t ST_RUN   = 3'd2;
  localparam job_state_t ST_DRAIN = 3'd3;
  localparam job_state_t ST_DONE  = 3'd4;

  // Pixel counters must hold D*D for the largest legal D.
  function automatic int cnt_w(input int max_dim);
    return 2 * $clog2(max_dim);
  endfunction

endpackage

// File: rtl/cnn_job_sequencer_if.sv
// Byte-wide AXI-Stream style descriptor port.
interface cnn_job_sequencer_if #(
  parameter int WEIGHT_RES = 8
);
  logic [WEIGHT_RES-1:0] cfg_tdata;
  logic                  cfg_tvalid;
  logic                  cfg_tlast;
  logic                  cfg_tready;

  modport master (output cfg_tdata, cfg_tvalid, cfg_tlast, input cfg_tready);
  modport slave  (input cfg_tdata, cfg_tvalid, cfg_tlast, output cfg_tready);
endinterface

// File: rtl/cnn_job_sequencer_cfg_desc_loader.sv
// Collects descriptor bytes into a shadow register, validates them and holds
// the result until the job FSM consumes it.
module cfg_desc_loader
  import cnn_pkg::*;
#(
  parameter int WEIGHT_RES   = WEIGHT_RES_DEF,
  parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int MAX_DIM      = MAX_DIM_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  cnn_job_sequencer_if.slave                     cfg,
  input  logic                                   consume,
  output logic                                   shadow_valid,
  output logic [$clog2(MAX_DIM)-1:0]             shadow_dim,
  output logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0]  shadow_weights,
  output logic                                   err_pulse
);

  localparam int NBYTES = KERNEL_SIZE + 2;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int DIM_W  = $clog2(MAX_DIM);

  logic [IDX_W-1:0]             idx;
  logic                         discard;
  logic [NBYTES*WEIGHT_RES-1:0] desc;
  logic                         beat;
  logic                         at_end;
  logic                         dim_ok;

  assign cfg.cfg_tready = !shadow_valid;
  assign beat           = cfg.cfg_tvalid && !shadow_valid;
  assign at_end         = (idx == IDX_W'(NBYTES - 1));
  // Full byte is checked so out-of-range values cannot alias into DIM_W bits.
  assign dim_ok         = (desc[WEIGHT_RES-1:0] >= WEIGHT_RES'(KERNEL_WIDTH)) &&
                          (desc[WEIGHT_RES-1:0] <= WEIGHT_RES'(MAX_DIM - 1));

  assign shadow_dim     = desc[DIM_W-1:0];
  assign shadow_weights = desc[NBYTES*WEIGHT_RES-1:WEIGHT_RES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      discard      <= 1'b0;
      desc         <= '0;
      shadow_valid <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (consume) shadow_valid <= 1'b0;
      if (beat) begin
        if (discard) begin
          if (cfg.cfg_tlast) discard <= 1'b0;
        end else begin
          desc[idx*WEIGHT_RES +: WEIGHT_RES] <= cfg.cfg_tdata;
          if (at_end) begin
            idx <= '0;
            if (!cfg.cfg_tlast) begin
              err_pulse <= 1'b1;
              discard   <= 1'b1;
            end else if (dim_ok) begin
              shadow_valid <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
            end
          end else if (cfg.cfg_tlast) begin
            idx       <= '0;
            err_pulse <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cnn_job_sequencer.sv
// Job-level controller: double-buffered descriptors, accelerator reset/gating,
// pixel-count based completion and sticky error reporting.
module cnn_job_sequencer
  import cnn_pkg::*;
#(
  parameter int WEIGHT_RES   = WEIGHT_RES_DEF,
  parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int MAX_DIM      = MAX_DIM_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic                                   clk_i,
  input  logic                                   resetn_i,
  cnn_job_sequencer_if.slave                     cfg,
  output logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0]  kernel_weights,
  output logic [$clog2(MAX_DIM)-1:0]             image_dimension,
  output logic                                   accel_resetn,
  output logic                                   in_gate,
  input  logic                                   px_in_fire,
  input  logic                                   px_out_fire,
  input  logic                                   px_out_last,
  output logic                                   busy,
  output logic                                   job_done,
  output logic                                   err,
  output logic [7:0]                             jobs_done
);

  localparam int DIM_W = $clog2(MAX_DIM);
  localparam int CNT_W = cnt_w(MAX_DIM);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  job_state_t                            state;
  logic [CNT_W-1:0]                      in_cnt, out_cnt, in_tot, out_tot;
  logic [CNT_W-1:0]                      dim_c, side_c;
  logic [WD_W-1:0]                       wd;
  logic                                  consume, shadow_valid, load_err;
  logic [DIM_W-1:0]                      shadow_dim;
  logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0] shadow_weights;
  logic                                  out_legal, last_exp, last_bad, stray_out, timeout;

  cfg_desc_loader #(
    .WEIGHT_RES  (WEIGHT_RES),
    .KERNEL_WIDTH(KERNEL_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .MAX_DIM     (MAX_DIM)
  ) u_loader (
    .clk           (clk_i),
    .rst_n         (resetn_i),
    .cfg           (cfg),
    .consume       (consume),
    .shadow_valid  (shadow_valid),
    .shadow_dim    (shadow_dim),
    .shadow_weights(shadow_weights),
    .err_pulse     (load_err)
  );

  assign consume   = (state == ST_IDLE) && shadow_valid;
  assign dim_c     = CNT_W'(shadow_dim);
  assign side_c    = dim_c - CNT_W'(KERNEL_WIDTH - 1);

  assign out_legal = (state == ST_RUN) || (state == ST_DRAIN);
  assign last_exp  = (out_cnt == out_tot - 1'b1);
  assign last_bad  = out_legal && px_out_fire && (px_out_last != last_exp);
  assign stray_out = !out_legal && px_out_fire;
  assign timeout   = (state == ST_DRAIN) && (out_cnt != out_tot) && !px_out_fire &&
                     (wd == WD_W'(TIMEOUT_CYC - 1));

  assign accel_resetn = out_legal;
  assign in_gate      = (state == ST_RUN);
  assign busy         = (state != ST_IDLE);
  assign job_done     = (state == ST_DONE);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state           <= ST_IDLE;
      kernel_weights  <= '0;
      image_dimension <= '0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      in_tot          <= '0;
      out_tot         <= '0;
      wd              <= '0;
      err             <= 1'b0;
      jobs_done       <= '0;
    end else begin
      err <= err | load_err | last_bad | stray_out | timeout;
      if (out_legal && px_out_fire) out_cnt <= out_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (shadow_valid) begin
            kernel_weights  <= shadow_weights;
            image_dimension <= shadow_dim;
            in_tot          <= dim_c * dim_c;
            out_tot         <= side_c * side_c;
            in_cnt          <= '0;
            out_cnt         <= '0;
            wd              <= '0;
            state           <= ST_ARM;
          end
        end
        ST_ARM: state <= ST_RUN;
        ST_RUN: begin
          if (px_in_fire) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == in_tot - 1'b1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Completion wins over the watchdog; any output fire rearms it.
          if (out_cnt == out_tot)  state <= ST_DONE;
          else if (px_out_fire)    wd    <= '0;
          else if (timeout)        state <= ST_DONE;
          else                     wd    <= wd + 1'b1;
        end
        ST_DONE: begin
          jobs_done <= jobs_done + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_job_sequencer.sv
// Scenario bench for cnn_job_sequencer with a descriptor scoreboard checked at job start.
module tb_cnn_job_sequencer;

  typedef struct packed {
    logic [4:0]  dim;
    logic [79:0] kw;
  } job_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [79:0] kernel_weights;
  logic [4:0]  image_dimension;
  logic        accel_resetn, in_gate, busy, job_done, err;
  logic [7:0]  jobs_done;
  logic        px_in_fire = 1'b0, px_out_fire = 1'b0, px_out_last = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   exp_jobs = 0;
  job_t exp_q[$];

  cnn_job_sequencer_if #(.WEIGHT_RES(8)) cfg_bus ();

  cnn_job_sequencer #(
    .WEIGHT_RES  (8),
    .KERNEL_WIDTH(3),
    .KERNEL_SIZE (9),
    .MAX_DIM     (32),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .cfg            (cfg_bus),
    .kernel_weights (kernel_weights),
    .image_dimension(image_dimension),
    .accel_resetn   (accel_resetn),
    .in_gate        (in_gate),
    .px_in_fire     (px_in_fire),
    .px_out_fire    (px_out_fire),
    .px_out_last    (px_out_last),
    .busy           (busy),
    .job_done       (job_done),
    .err            (err),
    .jobs_done      (jobs_done)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] rand_kw();
    logic [79:0] kw;
    for (int k = 0; k < 10; k++) kw[k*8 +: 8] = 8'($urandom);
    return kw;
  endfunction

  task automatic expect_job(input int d, input logic [79:0] kw);
    job_t e;
    e.dim = 5'(d);
    e.kw  = kw;
    exp_q.push_back(e);
  endtask

  // Pops the expected descriptor whenever a job starts (ARM) and checks ARM lasts one cycle.
  task automatic monitor();
    logic prev = 1'b0;
    logic arm_chk = 1'b0;
    job_t e;
    forever begin
      @(negedge clk);
      if (arm_chk) begin
        total++;
        if (accel_resetn !== 1'b1) begin
          bad++;
          $display("FAIL arm_len: accel_resetn=%0b want 1", accel_resetn);
        end
        arm_chk = 1'b0;
      end
      if (busy === 1'b1 && !prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL job_start: unexpected job dim=%0d, want no job", image_dimension);
        end else begin
          e = exp_q.pop_front();
          if ({image_dimension, kernel_weights, accel_resetn, in_gate} !== {e.dim, e.kw, 2'b00}) begin
            bad++;
            $display("FAIL job_start: dim=%0d kw=%h rstn=%0b gate=%0b want dim=%0d kw=%h 0 0",
                     image_dimension, kernel_weights, accel_resetn, in_gate, e.dim, e.kw);
          end
        end
        arm_chk = 1'b1;
      end
      prev = busy;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    px_in_fire = 1'b0; px_out_fire = 1'b0; px_out_last = 1'b0;
    cfg_bus.cfg_tvalid = 1'b0; cfg_bus.cfg_tlast = 1'b0; cfg_bus.cfg_tdata = '0;
    exp_q.delete();
    exp_jobs = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    cfg_bus.cfg_tdata = b; cfg_bus.cfg_tvalid = 1'b1; cfg_bus.cfg_tlast = l;
    while (cfg_bus.cfg_tready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL cfg_accept: tready=%0b after %0d cycles, want 1", cfg_bus.cfg_tready, n);
    end
    @(negedge clk);
    cfg_bus.cfg_tvalid = 1'b0; cfg_bus.cfg_tlast = 1'b0;
  endtask

  task automatic send_desc(input int d, input logic [79:0] kw, input int last_pos);
    logic [7:0] b;
    for (int k = 0; k <= last_pos; k++) begin
      b = (k == 0) ? 8'(d) : kw[(k-1)*8 +: 8];
      send_byte(b, k == last_pos);
    end
  endtask

  task automatic feed_job(input int d, input int n_out, input int last_at, input bit next_ready);
    int w = 0;
    int in_n = 0;
    while (in_gate !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
    if (w >= 3000) begin
      total++; bad++;
      $display("FAIL in_gate_wait: in_gate=%0b after %0d cycles, want 1", in_gate, w);
    end
    while (in_gate === 1'b1 && in_n < 2000) begin
      px_in_fire = 1'b1; in_n++;
      @(negedge clk);
    end
    px_in_fire = 1'b0;
    total++;
    if (in_n != d*d) begin
      bad++; $display("FAIL in_fires: got %0d want %0d", in_n, d*d);
    end
    for (int i = 0; i < n_out; i++) begin
      px_out_fire = 1'b1; px_out_last = (i == last_at);
      @(negedge clk);
    end
    px_out_fire = 1'b0; px_out_last = 1'b0;
    w = 0;
    while (job_done !== 1'b1 && w < 1500) begin @(negedge clk); w++; end
    total++;
    if (job_done !== 1'b1) begin
      bad++; $display("FAIL job_done_wait: job_done=%0b after %0d cycles, want 1", job_done, w);
    end else begin
      exp_jobs++;
      if (n_out == 0) begin
        total++;
        if (w < 1020 || w > 1028) begin
          bad++; $display("FAIL watchdog_len: %0d cycles, want ~1024", w);
        end
      end
      @(negedge clk);
      total++;
      if ({job_done, jobs_done} !== {1'b0, 8'(exp_jobs)}) begin
        bad++; $display("FAIL done_pulse: job_done=%0b jobs_done=%0d want 0 %0d", job_done, jobs_done, exp_jobs);
      end
      if (next_ready) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL gap_idle: busy=%0b want 0", busy); end
        @(negedge clk);
        total++;
        if ({busy, accel_resetn} !== 2'b10) begin
          bad++; $display("FAIL gap_arm: busy=%0b rstn=%0b want 1 0", busy, accel_resetn);
        end
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, accel_resetn, in_gate, job_done, err, jobs_done, kernel_weights, image_dimension, cfg_bus.cfg_tready}
        !== {5'b0, 8'h0, 80'h0, 5'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: busy=%0b rstn=%0b gate=%0b done=%0b err=%0b jobs=%0d kw=%h dim=%0d rdy=%0b want all 0, rdy 1",
               busy, accel_resetn, in_gate, job_done, err, jobs_done, kernel_weights, image_dimension, cfg_bus.cfg_tready);
    end
  endtask

  task automatic test_basic();
    logic [79:0] kw;
    kw = 80'h10090807060504030201;
    expect_job(5, kw);
    send_desc(5, kw, 10);
    feed_job(5, 9, 8, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL basic_err: err=%0b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] ka, kb, kc;
    ka = rand_kw(); kb = rand_kw(); kc = rand_kw();
    expect_job(6, ka);
    send_desc(6, ka, 10);
    fork
      feed_job(6, 16, 15, 1'b1);
      begin
        expect_job(4, kb);
        send_desc(4, kb, 10);
        total++;
        if ({cfg_bus.cfg_tready, busy} !== 2'b01) begin
          bad++; $display("FAIL shadow_full: tready=%0b busy=%0b want 0 1", cfg_bus.cfg_tready, busy);
        end
        expect_job(3, kc);
        send_desc(3, kc, 10);
      end
    join
    feed_job(4, 4, 3, 1'b1);
    feed_job(3, 1, 0, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL b2b_err: err=%0b want 0", err); end
  endtask

  task automatic test_short_desc();
    logic [79:0] kw;
    do_reset();
    kw = rand_kw();
    send_desc(7, kw, 6);
    repeat (3) @(negedge clk);
    total++;
    if ({err, busy, cfg_bus.cfg_tready} !== 3'b101) begin
      bad++; $display("FAIL short_desc: err=%0b busy=%0b rdy=%0b want 1 0 1", err, busy, cfg_bus.cfg_tready);
    end
    kw = rand_kw();
    expect_job(4, kw);
    send_desc(4, kw, 10);
    feed_job(4, 4, 3, 1'b0);
  endtask

  task automatic test_bad_dim();
    int dims[2] = '{2, 32};
    foreach (dims[i]) begin
      do_reset();
      send_desc(dims[i], rand_kw(), 10);
      repeat (4) @(negedge clk);
      total++;
      if ({err, busy, cfg_bus.cfg_tready} !== 3'b101) begin
        bad++; $display("FAIL bad_dim_%0d: err=%0b busy=%0b rdy=%0b want 1 0 1", dims[i], err, busy, cfg_bus.cfg_tready);
      end
    end
  endtask

  task automatic test_last_check();
    logic [79:0] kw;
    do_reset();
    kw = rand_kw();
    expect_job(3, kw);
    send_desc(3, kw, 10);
    feed_job(3, 1, 0, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL last_ok: err=%0b want 0", err); end
    kw = rand_kw();
    expect_job(4, kw);
    send_desc(4, kw, 10);
    feed_job(4, 4, 1, 1'b0);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL last_early: err=%0b want 1", err); end
  endtask

  task automatic test_stray_out();
    do_reset();
    px_out_fire = 1'b1;
    @(negedge clk);
    px_out_fire = 1'b0;
    @(negedge clk);
    total++;
    if ({err, busy} !== 2'b10) begin
      bad++; $display("FAIL stray_out: err=%0b busy=%0b want 1 0", err, busy);
    end
  endtask

  task automatic test_timeout();
    logic [79:0] kw;
    do_reset();
    kw = rand_kw();
    expect_job(3, kw);
    send_desc(3, kw, 10);
    feed_job(3, 0, -1, 1'b0);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: err=%0b want 1", err); end
  endtask

  task automatic test_reset_mid_run();
    logic [79:0] kw;
    int w = 0;
    do_reset();
    kw = rand_kw();
    expect_job(5, kw);
    send_desc(5, kw, 10);
    send_desc(6, rand_kw(), 10);
    while (in_gate !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    for (int i = 0; i < 10; i++) begin px_in_fire = 1'b1; @(negedge clk); end
    px_in_fire = 1'b0;
    total++;
    if ({busy, in_gate, cfg_bus.cfg_tready} !== 3'b110) begin
      bad++; $display("FAIL mid_run_pre: busy=%0b gate=%0b rdy=%0b want 1 1 0", busy, in_gate, cfg_bus.cfg_tready);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({busy, accel_resetn, in_gate, job_done, err, jobs_done, kernel_weights, image_dimension, cfg_bus.cfg_tready}
        !== {5'b0, 8'h0, 80'h0, 5'h0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: busy=%0b rstn=%0b gate=%0b kw=%h dim=%0d rdy=%0b want 0s, rdy 1",
               busy, accel_resetn, in_gate, kernel_weights, image_dimension, cfg_bus.cfg_tready);
    end
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, cfg_bus.cfg_tready} !== 2'b01) begin
      bad++; $display("FAIL shadow_dropped: busy=%0b rdy=%0b want 0 1", busy, cfg_bus.cfg_tready);
    end
  endtask

  initial begin
    cfg_bus.cfg_tvalid = 1'b0; cfg_bus.cfg_tlast = 1'b0; cfg_bus.cfg_tdata = '0;
    fork
      monitor();
    join_none
    do_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_desc();
    test_bad_dim();
    test_last_check();
    test_stray_out();
    test_timeout();
    test_reset_mid_run();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: %0d jobs never started, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
